// File: rtl/cs_hpm_counter_bank.sv
// rtl/cs_hpm_counter_bank.sv - machine-mode counter bank: mcycle, minstret, mhpmcounterN/mhpmeventN, mcountinhibit
// Writes always win over same-cycle increments; reads return pre-update state.
module cs_hpm_counter_bank #(
  parameter int XLEN       = 32,
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    csr_rd_en_i,
  input  logic                                    csr_wr_en_i,
  input  logic [11:0]                             csr_idx_i,
  input  logic [XLEN-1:0]                         csr_wdata_i,
  output logic [XLEN-1:0]                         csr_rdata_o,
  output logic                                    csr_hit_o,
  input  logic                                    cycle_en_i,
  input  logic                                    instret_i,
  input  logic [NUM_EVENTS-1:0]                   event_i,
  output logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0]  ovf_o,
  output logic                                    ovf_irq_o
);

  localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [6:0] NEV = 7'(NUM_EVENTS);
  localparam logic [63:0] IMPL64 = (64'd1 << (NUM_HPM + 3)) - 64'd1;
  localparam logic [31:0] INH_MASK = IMPL64[31:0] & 32'hFFFF_FFFD;

  function automatic logic [CNT_WIDTH-1:0] set_lo(input logic [CNT_WIDTH-1:0] c, input logic [31:0] w);
    logic [CNT_WIDTH-1:0] r;
    r = c;
    r[31:0] = w;
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] set_hi(input logic [CNT_WIDTH-1:0] c, input logic [31:0] w);
    logic [CNT_WIDTH-1:0] r;
    r = c;
    r[CNT_WIDTH-1:32] = w[CNT_WIDTH-33:0];
    return r;
  endfunction

  function automatic logic [31:0] hi32(input logic [CNT_WIDTH-1:0] c);
    return 32'(64'(c) >> 32);
  endfunction

  logic [4:0] n;
  logic is_lo, is_hi, is_ev;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic [31:0] inhibit;
  logic [CNT_WIDTH-1:0] hpm_cnt [NH];
  logic [5:0] evsel [NH];
  logic [NH-1:0] of;
  logic [63:0] ev_ext;
  logic [XLEN-1:0] rdata;

  assign n     = csr_idx_i[4:0];
  assign is_lo = (csr_idx_i[11:5] == 7'b1011_000);
  assign is_hi = (csr_idx_i[11:5] == 7'b1011_100);
  assign is_ev = (csr_idx_i[11:5] == 7'b0011_001);
  assign csr_hit_o = ((is_lo || is_hi) && n != 5'd1) || (is_ev && n != 5'd1 && n != 5'd2);

  // Bit 0 is "no event", so EVSEL indexes event_i directly with a one-bit offset.
  assign ev_ext = {63'(event_i), 1'b0};

  always_comb begin
    rdata = '0;
    if (csr_rd_en_i && csr_hit_o) begin
      if (is_lo) begin
        if (n == 5'd0) rdata = mcycle[31:0];
        if (n == 5'd2) rdata = minstret[31:0];
        for (int i = 0; i < NUM_HPM; i++)
          if (n == 5'(i + 3)) rdata = hpm_cnt[i][31:0];
      end else if (is_hi) begin
        if (n == 5'd0) rdata = hi32(mcycle);
        if (n == 5'd2) rdata = hi32(minstret);
        for (int i = 0; i < NUM_HPM; i++)
          if (n == 5'(i + 3)) rdata = hi32(hpm_cnt[i]);
      end else begin
        if (n == 5'd0) rdata = inhibit;
        for (int i = 0; i < NUM_HPM; i++)
          if (n == 5'(i + 3)) rdata = {of[i], 25'b0, evsel[i]};
      end
    end
  end
  assign csr_rdata_o = rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
    end else begin
      if (csr_wr_en_i && is_lo && n == 5'd0)      mcycle <= set_lo(mcycle, csr_wdata_i);
      else if (csr_wr_en_i && is_hi && n == 5'd0) mcycle <= set_hi(mcycle, csr_wdata_i);
      else if (cycle_en_i && !inhibit[0])         mcycle <= mcycle + ONE;

      if (csr_wr_en_i && is_lo && n == 5'd2)      minstret <= set_lo(minstret, csr_wdata_i);
      else if (csr_wr_en_i && is_hi && n == 5'd2) minstret <= set_hi(minstret, csr_wdata_i);
      else if (instret_i && !inhibit[2])          minstret <= minstret + ONE;

      if (csr_wr_en_i && is_ev && n == 5'd0) inhibit <= csr_wdata_i & INH_MASK;
    end
  end

  if (NUM_HPM > 0) begin : g_bank
    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
      localparam logic [4:0] IDX = 5'(i + 3);
      logic [CNT_WIDTH-1:0] cnt;
      logic [5:0] sel;
      logic of_q, inc, wr_lo, wr_hi, wr_ev;

      assign wr_lo = csr_wr_en_i && is_lo && n == IDX;
      assign wr_hi = csr_wr_en_i && is_hi && n == IDX;
      assign wr_ev = csr_wr_en_i && is_ev && n == IDX;
      assign inc   = ev_ext[sel] && !inhibit[i + 3];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          cnt  <= '0;
          sel  <= '0;
          of_q <= 1'b0;
        end else begin
          if (wr_lo)      cnt <= set_lo(cnt, csr_wdata_i);
          else if (wr_hi) cnt <= set_hi(cnt, csr_wdata_i);
          else if (inc)   cnt <= cnt + ONE;

          // A written OF beats a wrap; a written counter cannot wrap.
          if (wr_ev) begin
            of_q <= csr_wdata_i[31];
            sel  <= ({1'b0, csr_wdata_i[5:0]} <= NEV) ? csr_wdata_i[5:0] : 6'd0;
          end else if (inc && !wr_lo && !wr_hi && (&cnt)) begin
            of_q <= 1'b1;
          end
        end
      end

      assign hpm_cnt[i] = cnt;
      assign evsel[i]   = sel;
      assign of[i]      = of_q;
    end
  end else begin : g_none
    assign hpm_cnt[0] = '0;
    assign evsel[0]   = '0;
    assign of         = '0;
  end

  assign ovf_o     = of;
  assign ovf_irq_o = |of;

endmodule

// File: tb/tb_cs_hpm_counter_bank.sv
// tb/tb_cs_hpm_counter_bank.sv - scoreboard bench for cs_hpm_counter_bank with directed vectors
module tb_cs_hpm_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [11:0] idx = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        cycle_en = 1'b0, instret = 1'b0;
  logic [15:0] events = '0;
  logic [3:0]  ovf;
  logic        irq;
  logic        probe = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic        chk_ovf;
    logic        irq;
    logic [3:0]  ovf;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cs_hpm_counter_bank #(.XLEN(32), .NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVENTS(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_rd_en_i(rd_en), .csr_wr_en_i(wr_en),
    .csr_idx_i(idx), .csr_wdata_i(wdata), .csr_rdata_o(rdata), .csr_hit_o(hit),
    .cycle_en_i(cycle_en), .instret_i(instret), .event_i(events),
    .ovf_o(ovf), .ovf_irq_o(irq)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: consumes one expectation per probed cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (probe) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty: got probe, expected queued entry");
        end else begin
          e = sb.pop_front();
          chk(e.name, "rdata", rdata, e.data);
          chk(e.name, "hit", {31'b0, hit}, {31'b0, e.hit});
          if (e.chk_ovf) begin
            chk(e.name, "irq", {31'b0, irq}, {31'b0, e.irq});
            chk(e.name, "ovf", {28'b0, ovf}, {28'b0, e.ovf});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cyc);
    repeat (cyc) step();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idx = a; wdata = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic probe_cycle(input string nm, input logic [11:0] a, input logic en,
                             input logic [31:0] d, input logic h,
                             input logic co, input logic ir, input logic [3:0] ov);
    idx = a; rd_en = en; probe = 1'b1;
    sb.push_back('{nm, d, h, co, ir, ov});
    step();
    rd_en = 1'b0; probe = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] d, input logic h);
    probe_cycle(nm, a, 1'b1, d, h, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic rd_ovf(input string nm, input logic [11:0] a, input logic [31:0] d,
                        input logic ir, input logic [3:0] ov);
    probe_cycle(nm, a, 1'b1, d, 1'b1, 1'b1, ir, ov);
  endtask

  initial begin
    run(2);
    rst_n = 1'b1;
    rd_ovf("reset_mcycle", 12'hB00, 32'h0, 1'b0, 4'h0);

    // 10 active cycles, instret on 4 of them
    for (int i = 0; i < 10; i++) begin
      cycle_en = 1'b1;
      instret  = (i == 0 || i == 3 || i == 5 || i == 8);
      step();
    end
    cycle_en = 1'b0; instret = 1'b0;
    rd("mcycle10", 12'hB00, 32'd10, 1'b1);
    rd("minstret4", 12'hB02, 32'd4, 1'b1);
    rd("mcycleh0", 12'hB80, 32'd0, 1'b1);
    for (int i = 3; i < 7; i++) rd("mhpmevent_rst", 12'h320 + 12'(i), 32'h0, 1'b1);

    // event 5 -> event_i[4]
    wr(12'h323, 32'd5);
    events = 16'h0010; run(7); events = '0;
    rd("hpm3_7", 12'hB03, 32'd7, 1'b1);
    rd("evsel5", 12'h323, 32'd5, 1'b1);
    wr(12'h323, 32'd99);
    rd("evsel_illegal", 12'h323, 32'd0, 1'b1);
    events = 16'h0010; run(3); events = '0;
    rd("hpm3_stopped", 12'hB03, 32'd7, 1'b1);

    // full-width wrap sets OF
    wr(12'h323, 32'd1);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 16'h0001; step(); events = '0;
    rd_ovf("wrap_lo", 12'hB03, 32'h0, 1'b1, 4'h1);
    rd("wrap_hi", 12'hB83, 32'h0, 1'b1);
    rd("of_readback", 12'h323, 32'h8000_0001, 1'b1);
    wr(12'h323, 32'h0000_0001);
    rd_ovf("of_cleared", 12'h323, 32'h1, 1'b0, 4'h0);

    // inhibit write uses old inhibit in the write cycle
    cycle_en = 1'b1; instret = 1'b1; events = 16'h0001;
    wr(12'h320, 32'h9);
    run(5);
    cycle_en = 1'b0; instret = 1'b0; events = '0;
    rd("inh_mcycle", 12'hB00, 32'd11, 1'b1);
    rd("inh_minstret", 12'hB02, 32'd10, 1'b1);
    rd("inh_hpm3", 12'hB03, 32'd1, 1'b1);
    rd("inh_read", 12'h320, 32'h9, 1'b1);
    wr(12'h320, 32'hFFFF_FFFF);
    rd("inh_warl", 12'h320, 32'h0000_007D, 1'b1);
    wr(12'h320, 32'h0);

    // write beats increment; halves preserved
    events = 16'h0001;
    wr(12'hB03, 32'h0000_0100);
    events = '0;
    rd("wr_wins", 12'hB03, 32'h0000_0100, 1'b1);
    wr(12'hB83, 32'h0000_1234);
    rd("hi_keeps_lo", 12'hB03, 32'h0000_0100, 1'b1);
    rd("hi_written", 12'hB83, 32'h0000_1234, 1'b1);

    // wrap and OF=0 write in the same cycle
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 16'h0001;
    wr(12'h323, 32'h0000_0001);
    events = '0;
    rd_ovf("wrap_vs_ofwr", 12'hB03, 32'h0, 1'b0, 4'h0);

    // largest legal EVSEL on counter 6
    wr(12'h326, 32'd16);
    events = 16'h8000; run(2); events = '0;
    rd("evsel16", 12'hB06, 32'd2, 1'b1);
    wr(12'h326, 32'd17);
    rd("evsel17", 12'h326, 32'd0, 1'b1);

    // address space edges
    rd("unimpl_hi", 12'hB9F, 32'h0, 1'b1);
    rd("unimpl_ev", 12'h33F, 32'h0, 1'b1);
    rd("miss", 12'h7A0, 32'h0, 1'b0);
    probe_cycle("no_strobe", 12'hB00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);

    // software-set OF, then reset mid-count
    wr(12'h323, 32'h8000_0001);
    rd_ovf("sw_of", 12'h323, 32'h8000_0001, 1'b1, 4'h1);
    wr(12'h320, 32'h4);
    cycle_en = 1'b1; instret = 1'b1; events = 16'h0001;
    run(3);
    rst_n = 1'b0;
    wr(12'hB00, 32'd5);
    rst_n = 1'b1;
    cycle_en = 1'b0; instret = 1'b0; events = '0;
    rd_ovf("rst_mcycle", 12'hB00, 32'h0, 1'b0, 4'h0);
    rd("rst_minstret", 12'hB02, 32'h0, 1'b1);
    rd("rst_hpm3", 12'hB03, 32'h0, 1'b1);
    rd("rst_ev3", 12'h323, 32'h0, 1'b1);
    rd("rst_inhibit", 12'h320, 32'h0, 1'b1);

    run(2);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
